cache_arbiter: RTL and testbench
================================

CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, physical address width.
REQ-002 Parameter: LINE_W, 256, cache-line width in bits.
REQ-003 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: i_pmem_read  in  1  icache line-fill request.
REQ-006 Port: i_pmem_addr  in  ADDR_W  icache line address.
REQ-007 Port: i_pmem_rdata  out  LINE_W  line returned to icache.
REQ-008 Port: i_pmem_resp  out  1  icache completion pulse.
REQ-009 Port: d_pmem_read / d_pmem_write  in  1 each  dcache fill / writeback request.
REQ-010 Port: d_pmem_addr  in  ADDR_W  dcache line address.
REQ-011 Port: d_pmem_wdata  in  LINE_W  dcache writeback line.
REQ-012 Port: d_pmem_rdata  out  LINE_W  line returned to dcache.
REQ-013 Port: d_pmem_resp  out  1  dcache completion pulse.
REQ-014 Port: mem_read / mem_write  out  1 each  request to the shared line-level memory (cacheline adaptor).
REQ-015 Port: mem_addr  out  ADDR_W  latched address; mem_wdata  out  LINE_W  latched write line.
REQ-016 Port: mem_rdata  in  LINE_W; mem_resp  in  1  memory completion.

Function
REQ-017 FSM states: IDLE, I_BUSY, D_BUSY; exactly one transaction is outstanding at a time.
REQ-018 IDLE with any request -> grant taken at that edge; next cycle the state is I_BUSY or D_BUSY.
REQ-019 At grant: addr latched (plus wdata and write/read kind for dcache); mem_read/mem_write asserted from cycle N+1 (request in IDLE at cycle N) through and including the mem_resp cycle.
REQ-020 mem_addr/mem_wdata/op stay constant for the whole transaction even if requester inputs change.
REQ-021 Arbitration on simultaneous I and D requests: round-robin on last_grant; loser wins the next arbitration if still requesting.
REQ-022 Single requester always wins regardless of last_grant; last_grant updates on every grant.
REQ-023 On mem_resp in X_BUSY: X_pmem_resp=1 combinationally same cycle, X_pmem_rdata=mem_rdata; state -> IDLE at next edge.
REQ-024 Non-owner resp is always 0; non-owner rdata is 0.
REQ-025 One IDLE cycle between transactions minimum; back-to-back requests therefore issue every (latency+1) cycles.
REQ-026 mem_resp in IDLE: ignored, no resp forwarded, no state change.
REQ-027 Requester dropping its request mid-transaction: transaction still completes; resp pulse still emitted.
REQ-028 d_pmem_read and d_pmem_write both high: write takes precedence (illegal input; bench flags it).
REQ-029 Outputs in IDLE: mem_read=mem_write=0; mem_addr/mem_wdata hold last values.

Reset
REQ-030 reset sampled at edge: state=IDLE, last_grant=I (dcache wins first simultaneous tie), mem_addr=0, mem_wdata=0, all req/resp outputs 0 in the following cycle.
REQ-031 Reset mid-transaction abandons it; no resp pulse is emitted afterwards for it; a mem_resp arriving later is ignored per REQ-026.

Structure
REQ-032 State enum (arb_state_t) and grant enum (grant_t {GRANT_I, GRANT_D}) reside in the shared types package.
REQ-033 Single flat module; no sub-module; FSM next-state logic separated from latch registers.

Verification
REQ-034 I-only read addr 0x0000_0060, mem_resp after 5 cycles with rdata pattern A -> mem_read high 5 cycles, mem_addr 0x60, i_pmem_resp 1 cycle with A, d_pmem_resp 0.
REQ-035 I and D reads same cycle after reset (I 0x100, D 0x200) -> D served first (mem_addr 0x200), then I (0x100) after one IDLE cycle.
REQ-036 Both held continuously for 4 transactions -> grant order D,I,D,I.
REQ-037 D writeback 0x0000_0400 wdata B, requester changes addr/wdata mid-flight -> mem_write with 0x400/B unchanged until mem_resp; d_pmem_resp pulse.
REQ-038 reset asserted 2 cycles into I_BUSY, stray mem_resp afterwards -> outputs 0 after reset, no i_pmem_resp, state IDLE.
REQ-039 mem_resp pulse while IDLE -> no resp outputs, no transaction started.

Source files
------------

// File: rtl/cache_arbiter_pkg.sv
// Shared types for the I/D cache-to-memory arbiter: FSM states, grant
// identifiers and the round-robin selection rule.
package cache_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    I_BUSY,
    D_BUSY
  } arb_state_t;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } grant_t;

  // On a tie the side that did not win last time is chosen; a lone requester always wins.
  function automatic grant_t arbitrate(input logic i_req, input logic d_req,
                                       input grant_t last_grant);
    if (i_req && d_req) return (last_grant == GRANT_I) ? GRANT_D : GRANT_I;
    else if (d_req)     return GRANT_D;
    else                return GRANT_I;
  endfunction

endpackage

// File: rtl/cache_arbiter_if.sv
// Line-level memory bus between the arbiter (master) and the shared
// cacheline adaptor (slave).
interface cache_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_resp
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_resp
  );
endinterface

// File: rtl/cache_arbiter.sv
// Arbitrates icache fills and dcache fills/writebacks onto one line-level
// memory port; one transaction in flight, round-robin on simultaneous requests.
module cache_arbiter
  import cache_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_addr,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_addr,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  cache_arbiter_if.master   mem
);

  arb_state_t        state, state_next;
  grant_t            last_grant, grant;
  logic              d_req, grant_take, op_write;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;

  assign d_req      = d_pmem_read | d_pmem_write;
  assign grant      = arbitrate(i_pmem_read, d_req, last_grant);
  assign grant_take = (state == IDLE) && (i_pmem_read || d_req);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:           if (grant_take) state_next = (grant == GRANT_D) ? D_BUSY : I_BUSY;
      I_BUSY, D_BUSY: if (mem.mem_resp) state_next = IDLE;
      default:        state_next = IDLE;
    endcase
  end

  // Request snapshot is taken only at grant so the memory side never sees requester churn.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= GRANT_I;
      addr_q     <= '0;
      wdata_q    <= '0;
      op_write   <= 1'b0;
    end else if (grant_take) begin
      last_grant <= grant;
      if (grant == GRANT_D) begin
        addr_q   <= d_pmem_addr;
        wdata_q  <= d_pmem_wdata;
        op_write <= d_pmem_write;
      end else begin
        addr_q   <= i_pmem_addr;
        op_write <= 1'b0;
      end
    end
  end

  always_comb begin
    mem.mem_read  = 1'b0;
    mem.mem_write = 1'b0;
    i_pmem_resp   = 1'b0;
    d_pmem_resp   = 1'b0;
    i_pmem_rdata  = '0;
    d_pmem_rdata  = '0;
    case (state)
      I_BUSY: begin
        mem.mem_read = 1'b1;
        if (mem.mem_resp) begin
          i_pmem_resp  = 1'b1;
          i_pmem_rdata = mem.mem_rdata;
        end
      end
      D_BUSY: begin
        mem.mem_read  = !op_write;
        mem.mem_write = op_write;
        if (mem.mem_resp) begin
          d_pmem_resp  = 1'b1;
          d_pmem_rdata = mem.mem_rdata;
        end
      end
      default: ;
    endcase
  end

  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed scenarios plus a randomized
// stream checked against a transaction-level expected-order queue.
module tb_cache_arbiter;

  typedef struct {
    bit           is_d;
    logic [31:0]  addr;
    bit           rd;
    bit           wr;
    logic [255:0] wdata;
  } txn_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         i_pmem_read, d_pmem_read, d_pmem_write;
  logic [31:0]  i_pmem_addr, d_pmem_addr;
  logic [255:0] d_pmem_wdata, i_pmem_rdata, d_pmem_rdata;
  logic         i_pmem_resp, d_pmem_resp;

  logic         model_resp = 1'b0;
  logic [255:0] model_rdata = '0;
  logic         stray_resp = 1'b0;
  logic [255:0] stray_rdata = '0;
  bit           mem_auto = 1'b0;
  int           lat_min = 1, lat_max = 1;
  int           busy_cnt = 0, cur_lat = 1;

  int errors = 0;
  int checks = 0;

  logic [31:0] i_q[$];
  txn_t        d_q[$];
  txn_t        exp_q[$];

  cache_arbiter_if #(.ADDR_W(32), .LINE_W(256)) bus ();

  cache_arbiter #(.ADDR_W(32), .LINE_W(256)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_pmem_read  (i_pmem_read),
    .i_pmem_addr  (i_pmem_addr),
    .i_pmem_rdata (i_pmem_rdata),
    .i_pmem_resp  (i_pmem_resp),
    .d_pmem_read  (d_pmem_read),
    .d_pmem_write (d_pmem_write),
    .d_pmem_addr  (d_pmem_addr),
    .d_pmem_wdata (d_pmem_wdata),
    .d_pmem_rdata (d_pmem_rdata),
    .d_pmem_resp  (d_pmem_resp),
    .mem          (bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_resp  = model_resp | stray_resp;
  assign bus.mem_rdata = model_resp ? model_rdata : stray_rdata;

  function automatic logic [255:0] pat(input logic [31:0] a);
    return {8{a ^ 32'hA5A5_5A5A}};
  endfunction

  // Memory model: answers after a latency drawn per transaction.
  always @(posedge clk) begin
    #1;
    if (!mem_auto || model_resp) begin
      model_resp = 1'b0;
      busy_cnt   = 0;
    end else if (bus.mem_read || bus.mem_write) begin
      if (busy_cnt == 0) cur_lat = $urandom_range(lat_max, lat_min);
      busy_cnt++;
      if (busy_cnt >= cur_lat) begin
        model_resp  = 1'b1;
        model_rdata = pat(bus.mem_addr);
      end
    end
  end

  task automatic clear_inputs();
    i_pmem_read = 0; d_pmem_read = 0; d_pmem_write = 0;
    i_pmem_addr = '0; d_pmem_addr = '0; d_pmem_wdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; clear_inputs();
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; clear_inputs();
    repeat (2) @(negedge clk);
    checks++; if (bus.mem_read !== 1'b0) begin errors++; $display("FAIL rst_mem_read: got %b want 0", bus.mem_read); end
    checks++; if (bus.mem_write !== 1'b0) begin errors++; $display("FAIL rst_mem_write: got %b want 0", bus.mem_write); end
    checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr: got %h want 0", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 256'h0) begin errors++; $display("FAIL rst_mem_wdata: got %h want 0", bus.mem_wdata); end
    checks++; if (i_pmem_resp !== 1'b0 || d_pmem_resp !== 1'b0) begin errors++; $display("FAIL rst_resp: got i=%b d=%b want 0 0", i_pmem_resp, d_pmem_resp); end
    reset = 0;
  endtask

  task automatic test_i_read();
    int n_read = 0, n_write = 0, n_iresp = 0, n_dresp = 0, first = -1, bad_addr = 0;
    logic [255:0] got = '0;
    lat_min = 5; lat_max = 5; mem_auto = 1;
    i_pmem_read = 1; i_pmem_addr = 32'h0000_0060;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (bus.mem_read) begin
        n_read++;
        if (first < 0) first = c;
        if (bus.mem_addr !== 32'h60) bad_addr++;
        i_pmem_read = 0;
      end
      if (bus.mem_write) n_write++;
      if (i_pmem_resp) begin n_iresp++; got = i_pmem_rdata; end
      if (d_pmem_resp) n_dresp++;
    end
    checks++; if (first !== 1) begin errors++; $display("FAIL i_read_start: got cycle %0d want 1", first); end
    checks++; if (n_read !== 5) begin errors++; $display("FAIL i_read_len: got %0d want 5", n_read); end
    checks++; if (bad_addr !== 0 || n_write !== 0) begin errors++; $display("FAIL i_read_addr_op: got bad_addr=%0d writes=%0d want 0 0", bad_addr, n_write); end
    checks++; if (n_iresp !== 1) begin errors++; $display("FAIL i_read_resp_count: got %0d want 1", n_iresp); end
    checks++; if (got !== pat(32'h60)) begin errors++; $display("FAIL i_read_rdata: got %h want %h", got, pat(32'h60)); end
    checks++; if (n_dresp !== 0) begin errors++; $display("FAIL i_read_dresp: got %0d want 0", n_dresp); end
  endtask

  task automatic test_tie();
    int who[2], addr[2], start[2], resp_c[2];
    int ntx = 0;
    bit prev_busy = 0, busy;
    do_reset();
    lat_min = 3; lat_max = 3; mem_auto = 1;
    i_pmem_read = 1; i_pmem_addr = 32'h100;
    d_pmem_read = 1; d_pmem_addr = 32'h200;
    for (int c = 1; c <= 40 && ntx < 2; c++) begin
      @(negedge clk);
      busy = bus.mem_read || bus.mem_write;
      if (busy && !prev_busy) begin start[ntx] = c; addr[ntx] = int'(bus.mem_addr); end
      prev_busy = busy;
      if (i_pmem_resp || d_pmem_resp) begin
        who[ntx] = d_pmem_resp ? 1 : 0;
        resp_c[ntx] = c;
        checks++; if ((d_pmem_resp ? i_pmem_rdata : d_pmem_rdata) !== 256'h0) begin errors++; $display("FAIL tie_nonowner_rdata: got nonzero want 0"); end
        if (d_pmem_resp) d_pmem_read = 0; else i_pmem_read = 0;
        ntx++;
      end
    end
    checks++; if (ntx !== 2) begin errors++; $display("FAIL tie_timeout: got %0d txns want 2", ntx); end
    else begin
      checks++; if (who[0] !== 1 || addr[0] !== 32'h200) begin errors++; $display("FAIL tie_first: got who=%0d addr=%h want 1 200", who[0], addr[0]); end
      checks++; if (who[1] !== 0 || addr[1] !== 32'h100) begin errors++; $display("FAIL tie_second: got who=%0d addr=%h want 0 100", who[1], addr[1]); end
      checks++; if (start[1] !== resp_c[0] + 2) begin errors++; $display("FAIL tie_gap: got start %0d want %0d", start[1], resp_c[0] + 2); end
    end
  endtask

  task automatic test_alternation();
    int order[4];
    int want[4] = '{1, 0, 1, 0};
    int ntx = 0;
    do_reset();
    lat_min = 1; lat_max = 4; mem_auto = 1;
    i_pmem_read = 1; i_pmem_addr = 32'h300;
    d_pmem_read = 1; d_pmem_addr = 32'h340;
    for (int c = 0; c < 60 && ntx < 4; c++) begin
      @(negedge clk);
      if (i_pmem_resp || d_pmem_resp) begin
        order[ntx] = d_pmem_resp ? 1 : 0;
        checks++; if (bus.mem_addr !== (d_pmem_resp ? 32'h340 : 32'h300)) begin errors++; $display("FAIL alt_addr%0d: got %h", ntx, bus.mem_addr); end
        ntx++;
        if (ntx == 4) clear_inputs();
      end
    end
    clear_inputs();
    checks++; if (ntx !== 4) begin errors++; $display("FAIL alt_timeout: got %0d txns want 4", ntx); end
    else for (int k = 0; k < 4; k++) begin
      checks++; if (order[k] !== want[k]) begin errors++; $display("FAIL alt_order%0d: got %0d want %0d", k, order[k], want[k]); end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_writeback();
    logic [255:0] b = {8{32'hB0B1_B2B3}};
    int n_write = 0, n_read = 0, bad = 0, n_dresp = 0, n_iresp = 0;
    lat_min = 4; lat_max = 4; mem_auto = 1;
    d_pmem_write = 1; d_pmem_addr = 32'h0000_0400; d_pmem_wdata = b;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.mem_write) begin
        n_write++;
        if (bus.mem_addr !== 32'h400 || bus.mem_wdata !== b) bad++;
        d_pmem_write = 0; d_pmem_addr = 32'h999; d_pmem_wdata = ~b;
      end
      if (bus.mem_read) n_read++;
      if (d_pmem_resp) n_dresp++;
      if (i_pmem_resp) n_iresp++;
    end
    checks++; if (n_write !== 4 || n_read !== 0) begin errors++; $display("FAIL wb_len: got write=%0d read=%0d want 4 0", n_write, n_read); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL wb_stable: got %0d changed cycles want 0", bad); end
    checks++; if (n_dresp !== 1 || n_iresp !== 0) begin errors++; $display("FAIL wb_resp: got d=%0d i=%0d want 1 0", n_dresp, n_iresp); end
    checks++; if (bus.mem_addr !== 32'h400 || bus.mem_wdata !== b) begin errors++; $display("FAIL wb_idle_hold: got addr=%h want 400", bus.mem_addr); end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    int n_iresp = 0;
    bit seen = 0;
    lat_min = 10; lat_max = 10; mem_auto = 1;
    i_pmem_read = 1; i_pmem_addr = 32'h80;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      seen = bus.mem_read;
    end
    checks++; if (!seen) begin errors++; $display("FAIL rmid_grant_timeout: got no mem_read want grant"); end
    i_pmem_read = 0;
    @(negedge clk);
    reset = 1; mem_auto = 0;
    @(negedge clk);
    reset = 0;
    checks++; if (bus.mem_read !== 1'b0 || bus.mem_addr !== 32'h0) begin errors++; $display("FAIL rmid_outputs: got read=%b addr=%h want 0 0", bus.mem_read, bus.mem_addr); end
    stray_resp = 1; stray_rdata = pat(32'h80);
    #1;
    if (i_pmem_resp) n_iresp++;
    checks++; if (n_iresp !== 0 || d_pmem_resp !== 1'b0) begin errors++; $display("FAIL rmid_stray_resp: got i=%0d d=%b want 0 0", n_iresp, d_pmem_resp); end
    @(negedge clk);
    stray_resp = 0;
    checks++; if (bus.mem_read !== 1'b0 || i_pmem_resp !== 1'b0) begin errors++; $display("FAIL rmid_state: got read=%b resp=%b want idle", bus.mem_read, i_pmem_resp); end
  endtask

  task automatic test_stray_idle();
    int bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      stray_resp = 1; stray_rdata = {8{$urandom}};
      #1;
      checks++;
      if (i_pmem_resp !== 1'b0 || d_pmem_resp !== 1'b0 || i_pmem_rdata !== 256'h0 || d_pmem_rdata !== 256'h0) begin
        errors++; $display("FAIL stray_idle_resp%0d: got i=%b d=%b want 0 0", k, i_pmem_resp, d_pmem_resp);
      end
      @(negedge clk);
      stray_resp = 0;
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.mem_read || bus.mem_write) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL stray_idle_txn: got %0d busy cycles want 0", bad); end
  endtask

  task automatic drive_heads();
    i_pmem_read = (i_q.size() > 0);
    if (i_q.size() > 0) i_pmem_addr = i_q[0];
    d_pmem_read  = (d_q.size() > 0) && d_q[0].rd;
    d_pmem_write = (d_q.size() > 0) && d_q[0].wr;
    if (d_q.size() > 0) begin d_pmem_addr = d_q[0].addr; d_pmem_wdata = d_q[0].wdata; end
  endtask

  task automatic test_random();
    txn_t t, e;
    int ni, nd, busy_len = 0;
    bit need_idle = 0, take_d = 1;
    logic [255:0] own, other;
    do_reset();
    lat_min = 1; lat_max = 6; mem_auto = 1;
    ni = $urandom_range(10, 6); nd = $urandom_range(10, 6);
    for (int k = 0; k < ni; k++) i_q.push_back(32'($urandom_range(4095, 0)) << 5);
    for (int k = 0; k < nd; k++) begin
      t.is_d = 1; t.addr = 32'($urandom_range(4095, 0)) << 5; t.wdata = {8{$urandom}};
      case ($urandom_range(5, 0))
        0:       begin t.rd = 1; t.wr = 1; $display("note: illegal dcache read+write issued, write expected"); end
        1, 2:    begin t.rd = 0; t.wr = 1; end
        default: begin t.rd = 1; t.wr = 0; end
      endcase
      d_q.push_back(t);
    end
    // Expected service order: alternate starting with dcache while both sides queue work.
    begin
      int ii = 0, dd = 0;
      while (ii < ni || dd < nd) begin
        if (dd < nd && (take_d || ii >= ni)) begin e = d_q[dd]; dd++; take_d = 0; end
        else begin e.is_d = 0; e.addr = i_q[ii]; e.rd = 1; e.wr = 0; e.wdata = '0; ii++; take_d = 1; end
        exp_q.push_back(e);
      end
    end
    drive_heads();
    for (int c = 0; c < 3000 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (need_idle) begin
        checks++; if (bus.mem_read || bus.mem_write) begin errors++; $display("FAIL rnd_idle_gap: got busy want idle"); end
        need_idle = 0;
      end
      if (bus.mem_read || bus.mem_write) busy_len++;
      if (i_pmem_resp || d_pmem_resp) begin
        e = exp_q.pop_front();
        own   = d_pmem_resp ? d_pmem_rdata : i_pmem_rdata;
        other = d_pmem_resp ? i_pmem_rdata : d_pmem_rdata;
        checks++; if ((i_pmem_resp && d_pmem_resp) || (d_pmem_resp ? 1'b1 : 1'b0) !== e.is_d) begin errors++; $display("FAIL rnd_who: got i=%b d=%b want d=%b", i_pmem_resp, d_pmem_resp, e.is_d); end
        checks++; if (bus.mem_addr !== e.addr) begin errors++; $display("FAIL rnd_addr: got %h want %h", bus.mem_addr, e.addr); end
        checks++; if (bus.mem_write !== e.wr || bus.mem_read !== !e.wr) begin errors++; $display("FAIL rnd_op: got r=%b w=%b want w=%b", bus.mem_read, bus.mem_write, e.wr); end
        if (e.wr) begin
          checks++; if (bus.mem_wdata !== e.wdata) begin errors++; $display("FAIL rnd_wdata: got %h want %h", bus.mem_wdata, e.wdata); end
        end
        checks++; if (own !== pat(e.addr) || other !== 256'h0) begin errors++; $display("FAIL rnd_rdata: got %h want %h", own, pat(e.addr)); end
        checks++; if (busy_len !== cur_lat) begin errors++; $display("FAIL rnd_latency: got %0d want %0d", busy_len, cur_lat); end
        busy_len = 0; need_idle = 1;
        if (d_pmem_resp) void'(d_q.pop_front()); else void'(i_q.pop_front());
        drive_heads();
      end
    end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL rnd_timeout: got %0d pending want 0", exp_q.size()); end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_tie();
    test_alternation();
    test_writeback();
    test_reset_mid();
    test_stray_idle();
    test_random();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
